// File: rtl/adc_frame_packer.sv
// Scan sequencer and byte packetiser: on a trigger, reads four XADC auxiliary
// channels over DRP into a buffer, then streams a 10-byte framed packet
// (0xA5, four big-endian 16-bit samples, XOR checksum) on a valid/ready byte port.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for an external trigger or an auto-timer tick
// REQ   | one-cycle DRP read strobe for the current slot
// WAIT  | waiting for drdy (or the read timeout) for the current slot
// SEND  | presenting packet bytes 0..9 to the transmitter
module adc_frame_packer #(
   parameter int         SAMPLE_DIV  = 100000,
   parameter int         DRP_TIMEOUT = 255,
   parameter logic [6:0] ADDR0       = 7'h16,
   parameter logic [6:0] ADDR1       = 7'h17,
   parameter logic [6:0] ADDR2       = 7'h1E,
   parameter logic [6:0] ADDR3       = 7'h1F
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        trigger,
   input  logic        auto_en,
   output logic [6:0]  daddr,
   output logic        den,
   input  logic        drdy,
   input  logic [15:0] do_in,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        overrun,
   output logic        timeout
);

   localparam int TW = $clog2(SAMPLE_DIV);
   localparam int WW = $clog2(DRP_TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_DIV - 1);
   localparam logic [WW-1:0] WAIT_LAST  = WW'(DRP_TIMEOUT);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, SEND} state_t;

   state_t        state, state_nxt;
   logic [TW-1:0] timer;
   logic [WW-1:0] wait_cnt;
   logic [1:0]    slot;
   logic [3:0]    byte_idx;
   logic [15:0]   sbuf [4];
   logic [7:0]    csum;
   logic          auto_tick;
   logic          fire;
   logic          read_done;
   logic          last_byte_sent;

   assign auto_tick      = auto_en && (timer == TIMER_LAST);
   assign fire           = trigger | auto_tick;
   assign read_done      = (state == WAIT) && (drdy || (wait_cnt == WAIT_LAST));
   assign last_byte_sent = (state == SEND) && tx_ready && (byte_idx == 4'd9);

   // State register; reset abandons any frame in progress.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (fire) state_nxt = REQ;
         REQ:     state_nxt = WAIT;
         WAIT:    if (read_done) state_nxt = (slot == 2'd3) ? SEND : REQ;
         SEND:    if (last_byte_sent) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Timer, slot/byte indices, sample buffer and sticky flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         timer    <= '0;
         wait_cnt <= '0;
         slot     <= 2'd0;
         byte_idx <= 4'd0;
         overrun  <= 1'b0;
         timeout  <= 1'b0;
         for (int i = 0; i < 4; i++) sbuf[i] <= 16'h0000;
      end else begin
         if (!auto_en || timer == TIMER_LAST) timer <= '0;
         else                                 timer <= timer + 1'b1;

         // A trigger that cannot start a frame is dropped and remembered.
         if (state != IDLE && fire) overrun <= 1'b1;

         case (state)
            IDLE: if (fire) slot <= 2'd0;
            REQ:  wait_cnt <= '0;
            WAIT: begin
               wait_cnt <= wait_cnt + 1'b1;
               // drdy wins if it lands on the very last wait cycle.
               if (drdy) begin
                  sbuf[slot] <= do_in;
               end else if (wait_cnt == WAIT_LAST) begin
                  sbuf[slot] <= 16'hFFFF;
                  timeout    <= 1'b1;
               end
               if (read_done) begin
                  slot     <= slot + 2'd1;
                  byte_idx <= 4'd0;
               end
            end
            SEND: if (tx_ready) byte_idx <= byte_idx + 4'd1;
            default: ;
         endcase
      end
   end

   // Checksum covers the eight payload bytes only (not the 0xA5 header).
   always_comb begin
      csum = 8'h00;
      for (int i = 0; i < 4; i++) csum = csum ^ sbuf[i][15:8] ^ sbuf[i][7:0];
   end

   // Outputs are decoded from state so IDLE presents all-zero outputs.
   always_comb begin
      den      = (state == REQ);
      busy     = (state != IDLE);
      tx_valid = (state == SEND);
      daddr    = 7'h00;
      tx_data  = 8'h00;
      if (state == REQ || state == WAIT) begin
         case (slot)
            2'd0:    daddr = ADDR0;
            2'd1:    daddr = ADDR1;
            2'd2:    daddr = ADDR2;
            default: daddr = ADDR3;
         endcase
      end
      if (state == SEND) begin
         case (byte_idx)
            4'd0:    tx_data = 8'hA5;
            4'd1:    tx_data = sbuf[0][15:8];
            4'd2:    tx_data = sbuf[0][7:0];
            4'd3:    tx_data = sbuf[1][15:8];
            4'd4:    tx_data = sbuf[1][7:0];
            4'd5:    tx_data = sbuf[2][15:8];
            4'd6:    tx_data = sbuf[2][7:0];
            4'd7:    tx_data = sbuf[3][15:8];
            4'd8:    tx_data = sbuf[3][7:0];
            4'd9:    tx_data = csum;
            default: tx_data = 8'h00;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_frame_packer.sv
// Bench for adc_frame_packer: a DRP responder model feeds fixed sample values,
// expected bytes and DRP addresses are queued by the stimulus and consumed by
// independent monitors on the byte and DRP ports.
module tb_adc_frame_packer;

   localparam int DRP_TO = 20;
   localparam logic [79:0] FRAME_NORM = 80'hA5_12_30_45_60_78_90_AB_C0_84;
   localparam logic [79:0] FRAME_TO   = 80'hA5_12_30_45_60_FF_FF_AB_C0_6C;

   logic        clk = 1'b0;
   logic        reset;
   logic        trigger;
   logic        auto_en;
   logic [6:0]  daddr;
   logic        den;
   logic        drdy;
   logic [15:0] do_in;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic        overrun;
   logic        timeout;

   adc_frame_packer #(
      .SAMPLE_DIV  (200),
      .DRP_TIMEOUT (DRP_TO)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .trigger  (trigger),
      .auto_en  (auto_en),
      .daddr    (daddr),
      .den      (den),
      .drdy     (drdy),
      .do_in    (do_in),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .busy     (busy),
      .overrun  (overrun),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          ready_mode = 0;
   logic        ignore_en = 1'b0;
   logic [6:0]  ignore_addr = 7'h1E;
   logic [7:0]  exp_q[$];
   logic [6:0]  addr_q[$];
   int          last_den_cyc = 0;
   int          last_gap = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] drp_data(input logic [6:0] a);
      case (a)
         7'h16:   return 16'h1230;
         7'h17:   return 16'h4560;
         7'h1E:   return 16'h7890;
         7'h1F:   return 16'hABC0;
         default: return 16'h0000;
      endcase
   endfunction

   task automatic push_frame(input logic [79:0] f);
      for (int i = 0; i < 10; i++) exp_q.push_back(f[79-8*i -: 8]);
   endtask

   task automatic push_addrs(input int n);
      logic [27:0] a;
      a = {7'h16, 7'h17, 7'h1E, 7'h1F};
      for (int i = 0; i < n; i++) addr_q.push_back(a[27-7*i -: 7]);
   endtask

   task automatic pulse_trigger();
      @(posedge clk); #1 trigger = 1'b1;
      @(posedge clk); #1 trigger = 1'b0;
   endtask

   task automatic wait_idle(input int maxc);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((exp_q.size() != 0 || addr_q.size() != 0 || busy) && n < maxc);
      check("frame_done", n < maxc, 1);
   endtask

   // DRP responder: drdy one cycle after den, unless the address is being ignored.
   initial begin
      logic       pend;
      logic [6:0] pend_addr;
      pend = 1'b0;
      pend_addr = 7'h00;
      drdy = 1'b0;
      do_in = 16'h0000;
      forever begin
         @(posedge clk); #1;
         if (pend) begin
            drdy  = 1'b1;
            do_in = drp_data(pend_addr);
            pend  = 1'b0;
         end else begin
            drdy = 1'b0;
         end
         if (den && !(ignore_en && daddr == ignore_addr)) begin
            pend      = 1'b1;
            pend_addr = daddr;
         end
      end
   end

   // Transmitter readiness pattern.
   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = (cyc % 3 == 0);
            default: tx_ready = 1'b0;
         endcase
      end
   end

   // Byte-port monitor: scoreboard pop on each transfer, stability while stalled.
   initial begin
      logic       stalled;
      logic [7:0] stall_data;
      logic [7:0] e;
      stalled = 1'b0;
      stall_data = 8'h00;
      forever begin
         @(negedge clk);
         if (stalled) begin
            check("valid_held", tx_valid, 1);
            check("data_stable", tx_data, stall_data);
         end
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte: got %0h expected none", tx_data);
            end else begin
               e = exp_q.pop_front();
               check("tx_byte", tx_data, e);
            end
         end
         stalled    = tx_valid && !tx_ready;
         stall_data = tx_data;
      end
   end

   // DRP monitor: address order and den spacing.
   initial begin
      logic [6:0] ea;
      forever begin
         @(negedge clk);
         if (den) begin
            if (addr_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_den: got addr %0h expected none", daddr);
            end else begin
               ea = addr_q.pop_front();
               check("den_addr", daddr, ea);
            end
            last_gap     = cyc - last_den_cyc;
            last_den_cyc = cyc;
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int t_start[3];
      reset   = 1'b1;
      trigger = 1'b0;
      auto_en = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_daddr", daddr, 0);
      check("rst_den", den, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_timeout", timeout, 0);

      // Basic frame: latency, address order, busy length.
      push_frame(FRAME_NORM);
      push_addrs(4);
      pulse_trigger();
      @(negedge clk);
      check("trig_den", den, 1);
      check("trig_busy", busy, 1);
      n = 1;
      while (busy && n < 100) begin
         @(negedge clk);
         if (busy) n++;
         else break;
      end
      check("busy_cycles", n, 18);
      check("den_gap_fast", last_gap, 2);
      wait_idle(50);

      // Same frame with the transmitter accepting one cycle in three.
      ready_mode = 1;
      push_frame(FRAME_NORM);
      push_addrs(4);
      pulse_trigger();
      wait_idle(100);
      ready_mode = 0;
      check("timeout_still_0", timeout, 0);

      // Slot 2 read never answered.
      ignore_en = 1'b1;
      push_frame(FRAME_TO);
      push_addrs(4);
      pulse_trigger();
      wait_idle(200);
      ignore_en = 1'b0;
      check("timeout_set", timeout, 1);
      check("den_gap_timeout", last_gap, DRP_TO + 2);
      check("overrun_still_0", overrun, 0);

      // Trigger during SEND is dropped.
      push_frame(FRAME_NORM);
      push_addrs(4);
      pulse_trigger();
      n = 0;
      while (!tx_valid && n < 50) begin @(negedge clk); n++; end
      check("reach_send", tx_valid, 1);
      pulse_trigger();
      @(negedge clk);
      check("overrun_send", overrun, 1);
      wait_idle(50);
      repeat (30) @(negedge clk);
      check("no_extra_frame", busy, 0);

      // Reset while waiting on slot 2.
      push_addrs(3);
      pulse_trigger();
      n = 0;
      while (!(den && daddr == 7'h1E) && n < 50) begin @(negedge clk); n++; end
      check("reach_slot2", daddr, 7'h1E);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("mid_daddr", daddr, 0);
      check("mid_den", den, 0);
      check("mid_tx_data", tx_data, 0);
      check("mid_tx_valid", tx_valid, 0);
      check("mid_busy", busy, 0);
      check("mid_overrun", overrun, 0);
      check("mid_timeout", timeout, 0);
      check("mid_addr_q", addr_q.size(), 0);
      push_frame(FRAME_NORM);
      push_addrs(4);
      pulse_trigger();
      wait_idle(50);

      // Periodic triggering, three frames 200 cycles apart.
      for (int k = 0; k < 3; k++) begin
         push_frame(FRAME_NORM);
         push_addrs(4);
      end
      @(posedge clk); #1 auto_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         while (!busy && n < 400) begin @(negedge clk); n++; end
         t_start[k] = cyc;
         n = 0;
         while (busy && n < 100) begin @(negedge clk); n++; end
      end
      @(posedge clk); #1 auto_en = 1'b0;
      check("auto_period_1", t_start[1] - t_start[0], 200);
      check("auto_period_2", t_start[2] - t_start[1], 200);
      wait_idle(50);
      check("auto_overrun", overrun, 0);

      // Periodic triggering with the transmitter stalled.
      push_frame(FRAME_NORM);
      push_addrs(4);
      ready_mode = 2;
      @(posedge clk); #1 auto_en = 1'b1;
      n = 0;
      while (!busy && n < 400) begin @(negedge clk); n++; end
      check("stall_start", busy, 1);
      repeat (300) @(negedge clk);
      check("stall_overrun", overrun, 1);
      @(posedge clk); #1 begin
         auto_en = 1'b0;
         ready_mode = 0;
      end
      wait_idle(50);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
